// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
// Unsigned WIDTH-bit dividend/divisor; divide-by-zero answers in one cycle.
module sequential_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state, state_n;
    logic [WIDTH:0]   rem_q, rem_n;
    logic [WIDTH-1:0] quo_q, quo_n;
    logic [WIDTH-1:0] div_q, div_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [WIDTH-1:0] quotient_n, remainder_n;
    logic             busy_n, done_n, dbz_n;

    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] quo_step;
    logic             fits;

    // Partial remainder is WIDTH+1 bits, so the trial difference's MSB is its sign.
    always_comb begin
        shifted  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, div_q};
        fits     = ~trial[WIDTH];
        quo_step = {quo_q[WIDTH-2:0], fits};
    end

    always_comb begin
        state_n     = state;
        rem_n       = rem_q;
        quo_n       = quo_q;
        div_n       = div_q;
        cnt_n       = cnt_q;
        quotient_n  = quotient;
        remainder_n = remainder;
        busy_n      = busy;
        done_n      = 1'b0;
        dbz_n       = div_by_zero;
        case (state)
            IDLE: begin
                if (start) begin
                    if (B != '0) begin
                        quo_n   = A;
                        div_n   = B;
                        rem_n   = '0;
                        cnt_n   = '0;
                        busy_n  = 1'b1;
                        dbz_n   = 1'b0;
                        state_n = CALC;
                    end else begin
                        quotient_n  = '1;
                        remainder_n = A;
                        dbz_n       = 1'b1;
                        done_n      = 1'b1;
                    end
                end
            end
            CALC: begin
                rem_n = fits ? trial : shifted;
                quo_n = quo_step;
                cnt_n = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    quotient_n  = quo_step;
                    remainder_n = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    done_n      = 1'b1;
                    busy_n      = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            rem_q       <= rem_n;
            quo_q       <= quo_n;
            div_q       <= div_n;
            cnt_q       <= cnt_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
            busy        <= busy_n;
            done        <= done_n;
            div_by_zero <= dbz_n;
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: stimulus pushes expectations,
// a negedge monitor pops and checks on every done pulse.
module tb_sequential_divider;

    localparam int W = 4;

    logic         clk, reset, start;
    logic [W-1:0] A, B, quotient, remainder;
    logic         busy, done, div_by_zero;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dz;
        int cyc;
    } exp_t;

    exp_t q_exp[$];

    sequential_divider #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic issue(input int a, input int b, input bit track);
        exp_t e;
        A     = W'(a);
        B     = W'(b);
        start = 1'b1;
        if (track) begin
            e.a   = a;
            e.b   = b;
            e.dz  = (b == 0);
            e.q   = (b == 0) ? 15 : a / b;
            e.r   = (b == 0) ? a : a % b;
            e.cyc = cyc + 1 + ((b == 0) ? 0 : W);
            q_exp.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL wait_done: got timeout want done");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q_exp.size() != 0 || busy || done) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got timeout with %0d pending want 0", q_exp.size());
            q_exp.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (q_exp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 want no result pending (cyc=%0d)", cyc);
            end else begin
                e = q_exp.pop_front();
                chk("quotient", int'(quotient), e.q);
                chk("remainder", int'(remainder), e.r);
                chk("div_by_zero", int'(div_by_zero), e.dz);
                chk("done_cycle", cyc, e.cyc);
                if (e.dz == 0) begin
                    chk("identity", int'(quotient) * e.b + int'(remainder), e.a);
                    chk("rem_lt_b", int'(remainder < W'(e.b)), 1);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        #7;
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        #3 reset = 1'b0;

        // 15/3: busy for exactly 4 cycles, done right after
        @(negedge clk);
        issue(15, 3, 1);
        for (int i = 0; i < W; i++) begin
            chk("busy_during_calc", int'(busy), 1);
            chk("no_early_done", int'(done), 0);
            @(negedge clk);
        end
        chk("busy_after_calc", int'(busy), 0);
        chk("done_after_calc", int'(done), 1);
        wait_idle();

        // back-to-back, start raised in each done cycle
        @(negedge clk);
        issue(13, 4, 1);
        wait_done();
        issue(3, 5, 1);
        wait_done();
        issue(4, 2, 1);
        wait_idle();

        // divide by zero: one-cycle answer, busy never rises, flag holds
        @(negedge clk);
        issue(7, 0, 1);
        chk("dbz_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        chk("dbz_hold", int'(div_by_zero), 1);
        chk("dbz_q_hold", int'(quotient), 15);
        issue(6, 2, 1);
        chk("dbz_cleared", int'(div_by_zero), 0);
        wait_idle();

        // start while busy is ignored
        @(negedge clk);
        issue(9, 2, 1);
        @(negedge clk);
        issue(15, 1, 0);
        wait_idle();
        repeat (W + 2) @(negedge clk);

        // asynchronous reset mid-division, no done afterwards
        issue(14, 3, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_quotient", int'(quotient), 0);
        chk("arst_remainder", int'(remainder), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 3) @(negedge clk);
        issue(14, 3, 1);
        wait_idle();

        // exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                @(negedge clk);
                issue(a, b, 1);
                wait_idle();
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", q_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
